// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 slave word RAM with independent write (AW/W/B) and read (AR/R) channel FSMs.
// Optional feature: define AXI_SLAVE_RAM_WRAP_EN to support WRAP bursts with LEN 1, 3, 7 or 15.
module axi_slave_ram #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 10
) (
    input  logic        SLAVE_CLK,
    input  logic        SLAVE_RSTN,
    input  logic [1:0]  SLAVE_WR_ADDR_ID,
    input  logic [31:0] SLAVE_WR_ADDR,
    input  logic [7:0]  SLAVE_WR_ADDR_LEN,
    input  logic [1:0]  SLAVE_WR_ADDR_BURST,
    input  logic        SLAVE_WR_ADDR_VALID,
    output logic        SLAVE_WR_ADDR_READY,
    input  logic [31:0] SLAVE_WR_DATA,
    input  logic [3:0]  SLAVE_WR_STRB,
    input  logic        SLAVE_WR_DATA_LAST,
    input  logic        SLAVE_WR_DATA_VALID,
    output logic        SLAVE_WR_DATA_READY,
    output logic [1:0]  SLAVE_WR_BACK_ID,
    output logic [1:0]  SLAVE_WR_BACK_RESP,
    output logic        SLAVE_WR_BACK_VALID,
    input  logic        SLAVE_WR_BACK_READY,
    input  logic [1:0]  SLAVE_RD_ADDR_ID,
    input  logic [31:0] SLAVE_RD_ADDR,
    input  logic [7:0]  SLAVE_RD_ADDR_LEN,
    input  logic [1:0]  SLAVE_RD_ADDR_BURST,
    input  logic        SLAVE_RD_ADDR_VALID,
    output logic        SLAVE_RD_ADDR_READY,
    output logic [1:0]  SLAVE_RD_BACK_ID,
    output logic [31:0] SLAVE_RD_DATA,
    output logic [1:0]  SLAVE_RD_DATA_RESP,
    output logic        SLAVE_RD_DATA_LAST,
    output logic        SLAVE_RD_DATA_VALID,
    input  logic        SLAVE_RD_DATA_READY
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH];

    function automatic logic addr_oor(input logic [31:0] addr);
        addr_oor = (addr < BASE_ADDR) || (((addr - BASE_ADDR) >> (ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_index(input logic [31:0] addr);
        addr_index = ADDR_WIDTH'((addr - BASE_ADDR) >> 2);
    endfunction

    // WRAP keeps the upper index bits and advances only the bits inside the LEN+1 window.
    function automatic logic [ADDR_WIDTH-1:0] next_index(input logic [ADDR_WIDTH-1:0] idx,
                                                         input logic [1:0]            burst,
                                                         input logic [7:0]            len);
        logic [ADDR_WIDTH-1:0] mask;
        mask = ADDR_WIDTH'(len);
        case (burst)
            2'b00:   next_index = idx;
            2'b10:   next_index = (idx & ~mask) | ((idx + ADDR_WIDTH'(1)) & mask);
            default: next_index = idx + ADDR_WIDTH'(1);
        endcase
    endfunction

    function automatic logic [1:0] resp_code(input logic oor, input logic err);
        if (oor)      resp_code = 2'b11;
        else if (err) resp_code = 2'b10;
        else          resp_code = 2'b00;
    endfunction

`ifdef AXI_SLAVE_RAM_WRAP_EN
    function automatic logic wrap_len_ok(input logic [7:0] len);
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
`endif

    logic aw_bad;
    logic ar_bad;
`ifdef AXI_SLAVE_RAM_WRAP_EN
    assign aw_bad = (SLAVE_WR_ADDR_BURST == 2'b11) ||
                    ((SLAVE_WR_ADDR_BURST == 2'b10) && !wrap_len_ok(SLAVE_WR_ADDR_LEN));
    assign ar_bad = (SLAVE_RD_ADDR_BURST == 2'b11) ||
                    ((SLAVE_RD_ADDR_BURST == 2'b10) && !wrap_len_ok(SLAVE_RD_ADDR_LEN));
`else
    assign aw_bad = SLAVE_WR_ADDR_BURST[1];
    assign ar_bad = SLAVE_RD_ADDR_BURST[1];
`endif

    // ---------------- write channel ----------------
    w_state_t              w_state, w_state_nx;
    logic [1:0]            w_id;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [7:0]            w_len;
    logic [1:0]            w_burst;
    logic [7:0]            w_cnt;
    logic                  w_oor, w_bad, w_mis;
    logic [1:0]            b_resp;
    logic                  aw_ready, w_ready, b_valid;
    logic                  aw_hs, w_hs, w_mis_now;

    always_comb begin
        w_state_nx = w_state;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (SLAVE_WR_ADDR_VALID) w_state_nx = W_DATA;
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_LAST) w_state_nx = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (SLAVE_WR_BACK_READY) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) w_state <= W_IDLE;
        else             w_state <= w_state_nx;
    end

    assign aw_hs     = aw_ready && SLAVE_WR_ADDR_VALID;
    assign w_hs      = w_ready && SLAVE_WR_DATA_VALID;
    // A burst is short if LAST comes early, long if the LEN beat arrives without LAST.
    assign w_mis_now = SLAVE_WR_DATA_LAST ? (w_cnt != w_len) : (w_cnt == w_len);

    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_oor   <= 1'b0;
            w_bad   <= 1'b0;
            w_mis   <= 1'b0;
            b_resp  <= '0;
        end else begin
            if (aw_hs) begin
                w_id    <= SLAVE_WR_ADDR_ID;
                w_idx   <= addr_index(SLAVE_WR_ADDR);
                w_len   <= SLAVE_WR_ADDR_LEN;
                w_burst <= SLAVE_WR_ADDR_BURST;
                w_cnt   <= '0;
                w_oor   <= addr_oor(SLAVE_WR_ADDR);
                w_bad   <= aw_bad;
                w_mis   <= 1'b0;
            end
            if (w_hs) begin
                w_idx <= next_index(w_idx, w_burst, w_len);
                w_cnt <= w_cnt + 8'd1;
                if (w_mis_now) w_mis <= 1'b1;
                if (SLAVE_WR_DATA_LAST) b_resp <= resp_code(w_oor, w_bad || w_mis || w_mis_now);
            end
        end
    end

    always_ff @(posedge SLAVE_CLK) begin
        if (w_hs && !w_oor && !w_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (SLAVE_WR_STRB[b]) mem[w_idx][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
            end
        end
    end

    assign SLAVE_WR_ADDR_READY = aw_ready;
    assign SLAVE_WR_DATA_READY = w_ready;
    assign SLAVE_WR_BACK_VALID = b_valid;
    assign SLAVE_WR_BACK_ID    = w_id;
    assign SLAVE_WR_BACK_RESP  = b_resp;

    // ---------------- read channel ----------------
    r_state_t              r_state, r_state_nx;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [7:0]            r_len;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  r_zero;
    logic                  ar_ready, ar_hs, r_take;
    logic                  ar_zero;
    logic [ADDR_WIDTH-1:0] ar_idx;
    logic [1:0]            rid_p1;
    logic [31:0]           rdata_p1;
    logic [1:0]            rresp_p1;
    logic                  rlast_p1;
    logic                  vld_p1;

    always_comb begin
        r_state_nx = r_state;
        ar_ready   = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (SLAVE_RD_ADDR_VALID) r_state_nx = R_DATA;
            end
            R_DATA: begin
                if (vld_p1 && SLAVE_RD_DATA_READY && rlast_p1) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) r_state <= R_IDLE;
        else             r_state <= r_state_nx;
    end

    assign ar_hs   = ar_ready && SLAVE_RD_ADDR_VALID;
    assign r_take  = vld_p1 && SLAVE_RD_DATA_READY;
    assign ar_idx  = addr_index(SLAVE_RD_ADDR);
    assign ar_zero = addr_oor(SLAVE_RD_ADDR) || ar_bad;

    // ---- stage p1: beat register loaded from the combinational array read ----
    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            r_idx    <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            rid_p1   <= '0;
            rdata_p1 <= '0;
            rresp_p1 <= '0;
            rlast_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (ar_hs) begin
            r_len    <= SLAVE_RD_ADDR_LEN;
            r_burst  <= SLAVE_RD_ADDR_BURST;
            r_zero   <= ar_zero;
            r_idx    <= next_index(ar_idx, SLAVE_RD_ADDR_BURST, SLAVE_RD_ADDR_LEN);
            r_cnt    <= 8'd1;
            rid_p1   <= SLAVE_RD_ADDR_ID;
            rdata_p1 <= ar_zero ? 32'd0 : mem[ar_idx];
            rresp_p1 <= resp_code(addr_oor(SLAVE_RD_ADDR), ar_bad);
            rlast_p1 <= (SLAVE_RD_ADDR_LEN == 8'd0);
            vld_p1   <= 1'b1;
        end else if (r_take) begin
            if (rlast_p1) begin
                vld_p1   <= 1'b0;
                rlast_p1 <= 1'b0;
            end else begin
                rdata_p1 <= r_zero ? 32'd0 : mem[r_idx];
                rlast_p1 <= (r_cnt == r_len);
                r_idx    <= next_index(r_idx, r_burst, r_len);
                r_cnt    <= r_cnt + 8'd1;
            end
        end
    end

    assign SLAVE_RD_ADDR_READY = ar_ready;
    assign SLAVE_RD_BACK_ID    = rid_p1;
    assign SLAVE_RD_DATA       = rdata_p1;
    assign SLAVE_RD_DATA_RESP  = rresp_p1;
    assign SLAVE_RD_DATA_LAST  = rlast_p1;
    assign SLAVE_RD_DATA_VALID = vld_p1;

endmodule
